// File: rtl/maze_lookup_arbiter_if.sv
// Bus between the sprite movement FSMs, the shared maze lookup arbiter and the maze wall ROM.
// slave  : the arbiter side (takes requests and ROM data, returns grants, results and ROM reads)
// master : the environment side (sprites plus ROM)
interface maze_lookup_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 6
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*10-1:0] req_x;
  logic [NUM_REQ*10-1:0] req_y;
  logic [NUM_REQ*4-1:0]  req_dir;
  logic [NUM_REQ-1:0]    gnt;
  logic                  busy;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [7:0]            rsp_row;
  logic [7:0]            rsp_col;
  logic                  rsp_blocked;
  logic                  maze_rd_en;
  logic [ADDR_W-1:0]     maze_addr;
  logic                  maze_data;

  modport slave (
    input  req, req_x, req_y, req_dir, maze_data,
    output gnt, busy, rsp_valid, rsp_id, rsp_row, rsp_col, rsp_blocked,
           maze_rd_en, maze_addr
  );

  modport master (
    output req, req_x, req_y, req_dir, maze_data,
    input  gnt, busy, rsp_valid, rsp_id, rsp_row, rsp_col, rsp_blocked,
           maze_rd_en, maze_addr
  );
endinterface

// File: rtl/maze_lookup_arbiter.sv
// Shares one pixel-to-tile converter and the maze wall ROM port between the sprites.
// Grants one requester at a time, forms a probe pixel ahead of the sprite, divides it by
// TILE with an iterative subtractor, reads the wall bit and returns row/col/blocked.
// Optional feature macro: PRIO_PACMAN_EN -- requester 0 (pacman) always wins in IDLE and
// the remaining requesters round-robin among themselves.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a request; grant pulse and operand capture
// ST_CALC | one subtract step per cycle on both axes until both < TILE
// ST_MEM  | ROM read strobe (suppressed when the probe is outside)
// ST_RESP | result strobe; wall bit sampled from the ROM this cycle
module maze_lookup_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TILE    = 60,
  parameter int COLS    = 8,
  parameter int ROWS    = 8,
  parameter int S_X     = 150,
  parameter int S_Y     = 34,
  parameter int P_OFF   = 15,
  parameter int ADDR_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  maze_lookup_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_MEM  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

`ifdef PRIO_PACMAN_EN
  localparam bit PRIO_PACMAN = 1'b1;
`else
  localparam bit PRIO_PACMAN = 1'b0;
`endif

  localparam logic [10:0]        TILE_V  = 11'(TILE);
  localparam logic signed [10:0] S_X_V   = 11'(S_X);
  localparam logic signed [10:0] S_Y_V   = 11'(S_Y);
  localparam logic signed [10:0] P_OFF_V = 11'(P_OFF);
  localparam logic [7:0]         ROWS_V  = 8'(ROWS);
  localparam logic [7:0]         COLS_V  = 8'(COLS);
  localparam logic [ID_W-1:0]    PTR_RST = ID_W'(NUM_REQ - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [10:0]       rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [7:0]        col_q, col_d, row_q, row_d;
  logic              outside_q, outside_d;
  logic [ID_W-1:0]   hold_id_q, hold_id_d;
  logic [7:0]        hold_row_q, hold_row_d, hold_col_q, hold_col_d;
  logic              hold_blk_q, hold_blk_d;

  logic              win_found;
  int                win_idx;
  int                cand;
  logic [9:0]        sel_x, sel_y;
  logic [3:0]        sel_dir;
  logic signed [10:0] probe_x, probe_y;
  logic              calc_done;
  logic              outside_eff;
  logic              blocked_now;
  logic [ADDR_W-1:0] addr_now;

  // Round-robin winner search starting one past the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    cand      = 0;
    if (PRIO_PACMAN && bus.req[0]) begin
      win_found = 1'b1;
    end else begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        cand = (int'(ptr_q) + off) % NUM_REQ;
        if (!win_found && bus.req[cand] && !(PRIO_PACMAN && cand == 0)) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  // Probe pixel of the winning requester, relative to the maze origin.
  always_comb begin
    sel_x   = bus.req_x[10*win_idx +: 10];
    sel_y   = bus.req_y[10*win_idx +: 10];
    sel_dir = bus.req_dir[4*win_idx +: 4];
    probe_x = $signed({1'b0, sel_x}) - S_X_V;
    probe_y = $signed({1'b0, sel_y}) - S_Y_V;
    if (sel_dir[3])      probe_x = probe_x - P_OFF_V;
    else if (sel_dir[2]) probe_y = probe_y - P_OFF_V;
    else if (sel_dir[1]) probe_x = probe_x + P_OFF_V;
    else if (sel_dir[0]) probe_y = probe_y + P_OFF_V;
  end

  // Status derived from the registered division state.
  always_comb begin
    calc_done   = (rem_x_q < TILE_V) && (rem_y_q < TILE_V);
    outside_eff = outside_q || (row_q >= ROWS_V) || (col_q >= COLS_V);
    blocked_now = outside_eff || bus.maze_data;
    addr_now    = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_found) state_d = ST_CALC;
      ST_CALC: if (calc_done) state_d = ST_MEM;
      ST_MEM:  state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand capture on grant, iterative divide, result hold.
  always_comb begin
    ptr_d      = ptr_q;
    id_d       = id_q;
    rem_x_d    = rem_x_q;
    rem_y_d    = rem_y_q;
    col_d      = col_q;
    row_d      = row_q;
    outside_d  = outside_q;
    hold_id_d  = hold_id_q;
    hold_row_d = hold_row_q;
    hold_col_d = hold_col_q;
    hold_blk_d = hold_blk_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          id_d  = ID_W'(win_idx);
          // pacman grants under priority mode leave the ghost rotation untouched
          if (!(PRIO_PACMAN && win_idx == 0)) ptr_d = ID_W'(win_idx);
          row_d = 8'd0;
          col_d = 8'd0;
          if (probe_x[10] || probe_y[10]) begin
            outside_d = 1'b1;
            rem_x_d   = 11'd0;
            rem_y_d   = 11'd0;
          end else begin
            outside_d = 1'b0;
            rem_x_d   = probe_x;
            rem_y_d   = probe_y;
          end
        end
      end
      ST_CALC: begin
        if (rem_x_q >= TILE_V) begin
          rem_x_d = rem_x_q - TILE_V;
          col_d   = (col_q == 8'hFF) ? col_q : col_q + 8'd1;
        end
        if (rem_y_q >= TILE_V) begin
          rem_y_d = rem_y_q - TILE_V;
          row_d   = (row_q == 8'hFF) ? row_q : row_q + 8'd1;
        end
      end
      ST_RESP: begin
        hold_id_d  = id_q;
        hold_row_d = row_q;
        hold_col_d = col_q;
        hold_blk_d = blocked_now;
      end
      default: ;
    endcase
  end

  // Outputs; forced quiet while reset is asserted.
  always_comb begin
    bus.gnt         = '0;
    bus.busy        = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_id      = hold_id_q;
    bus.rsp_row     = hold_row_q;
    bus.rsp_col     = hold_col_q;
    bus.rsp_blocked = hold_blk_q;
    bus.maze_rd_en  = 1'b0;
    bus.maze_addr   = '0;
    if (rst) begin
      bus.rsp_id      = '0;
      bus.rsp_row     = 8'd0;
      bus.rsp_col     = 8'd0;
      bus.rsp_blocked = 1'b0;
    end else begin
      bus.busy = (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: if (win_found) bus.gnt[win_idx] = 1'b1;
        ST_MEM: begin
          if (!outside_eff) begin
            bus.maze_rd_en = 1'b1;
            bus.maze_addr  = addr_now;
          end
        end
        ST_RESP: begin
          bus.rsp_valid   = 1'b1;
          bus.rsp_id      = id_q;
          bus.rsp_row     = row_q;
          bus.rsp_col     = col_q;
          bus.rsp_blocked = blocked_now;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= PTR_RST;
      id_q       <= '0;
      rem_x_q    <= 11'd0;
      rem_y_q    <= 11'd0;
      col_q      <= 8'd0;
      row_q      <= 8'd0;
      outside_q  <= 1'b0;
      hold_id_q  <= '0;
      hold_row_q <= 8'd0;
      hold_col_q <= 8'd0;
      hold_blk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      rem_x_q    <= rem_x_d;
      rem_y_q    <= rem_y_d;
      col_q      <= col_d;
      row_q      <= row_d;
      outside_q  <= outside_d;
      hold_id_q  <= hold_id_d;
      hold_row_q <= hold_row_d;
      hold_col_q <= hold_col_d;
      hold_blk_q <= hold_blk_d;
    end
  end

endmodule
